// File: rtl/double_frame_buffer.sv
// double_frame_buffer: two-bank pixel store with vsync-aligned bank swap.
// The display reads the front bank with one cycle of latency while the
// renderer writes the back bank. A swap request is held until the next
// vsync and then exchanges the banks.
// Optional feature macro FB_CLEAR_EN: after each swap, fill the new back bank
// with clear_color (one word per cycle) and remember a swap request that
// arrives while that fill is running.
module double_frame_buffer #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  vsync,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_sel,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  busy
);

  localparam int unsigned           DEPTH     = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SWAP_PENDING = 2'd1,
    CLEARING     = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   do_swap;

  // Both banks share one array, addressed as {bank, pixel}. This gives one
  // write port (renderer or clear engine) and one read port (display).
  logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)] = '{default: '0};
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef FB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nx;
  logic                  swap_latch, latch_nx;
`else
  logic unused_clear_color;
  assign unused_clear_color = ^clear_color;
`endif

  // Next-state logic, swap decision and selection of the memory write port
  always_comb begin
    state_nx  = state;
    do_swap   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = write_data;
`ifdef FB_CLEAR_EN
    clr_cnt_nx = clr_cnt;
    latch_nx   = swap_latch;
`endif
    unique case (state)
      IDLE: begin
        if (write_en && ({1'b0, write_addr} < DEPTH_X)) mem_we = 1'b1;
        if (swap_req) begin
          if (vsync) do_swap = 1'b1;
          else       state_nx = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (vsync) do_swap = 1'b1;
      end
      CLEARING: begin
`ifdef FB_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = clear_color;
        if (swap_req) latch_nx = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          clr_cnt_nx = '0;
          // A request on the final fill cycle counts as latched.
          if (swap_req || swap_latch) begin
            state_nx = SWAP_PENDING;
            latch_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
    if (do_swap) begin
`ifdef FB_CLEAR_EN
      state_nx   = CLEARING;
      clr_cnt_nx = '0;
`else
      state_nx   = IDLE;
`endif
    end
    if (rst) mem_we = 1'b0;
  end

  // Control registers: state, bank select, swap pulse, clear bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt    <= '0;
      swap_latch <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      swap_done <= do_swap;
      if (do_swap) front_sel <= ~front_sel;
`ifdef FB_CLEAR_EN
      clr_cnt    <= clr_cnt_nx;
      swap_latch <= latch_nx;
`endif
    end
  end

  // Back-bank write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[{~front_sel, mem_waddr}] <= mem_wdata;
  end

  // Registered front-bank read
  always_ff @(posedge clk) begin
    if (rst) read_data <= '0;
    else     read_data <= mem[{front_sel, read_addr}];
  end

  assign write_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_double_frame_buffer.sv
// Bench for double_frame_buffer (WIDTH=4, HEIGHT=2): behavioural model plus
// directed scenarios; clear-engine scenarios run when FB_CLEAR_EN is defined.
module tb_double_frame_buffer;
  localparam int W = 4, H = 2, DW = 12, AW = 3, N = 8;
`ifdef FB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] read_addr = '0;
  logic [DW-1:0] read_data;
  logic          vsync = 1'b0, swap_req = 1'b0;
  logic          swap_done, front_sel;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_ready;
  logic [DW-1:0] clear_color = '0;
  logic          busy;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  double_frame_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(read_data),
    .vsync(vsync), .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .write_ready(write_ready), .clear_color(clear_color), .busy(busy)
  );

  // Behavioural model: banks as arrays, a pending flag and a fill countdown
  logic [DW-1:0] m_mem [2][N];
  bit            m_front, m_done, m_pending, m_latch, m_idle, m_swap;
  int            m_clr_left, m_clr_addr;
  logic [DW-1:0] m_rd;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) m_mem[b][a] = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_front = 0; m_done = 0; m_rd = '0; m_pending = 0;
      m_clr_left = 0; m_clr_addr = 0; m_latch = 0;
    end else begin
      m_idle = !m_pending && (m_clr_left == 0);
      m_swap = 0;
      m_rd = m_mem[m_front][read_addr];
      if (m_idle) begin
        if (write_en && int'(write_addr) < N) m_mem[!m_front][write_addr] = write_data;
        if (swap_req) begin
          if (vsync) m_swap = 1;
          else       m_pending = 1;
        end
      end else if (m_pending) begin
        if (vsync) begin m_swap = 1; m_pending = 0; end
      end else begin
        m_mem[!m_front][m_clr_addr] = clear_color;
        m_clr_addr++;
        m_clr_left--;
        if (swap_req) m_latch = 1;
        if (m_clr_left == 0 && m_latch) begin m_pending = 1; m_latch = 0; end
      end
      if (m_swap) begin
        m_front = !m_front;
        if (CLR) begin m_clr_left = N; m_clr_addr = 0; end
      end
      m_done = m_swap;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model read_data", 32'(read_data), 32'(m_rd));
      chk("model front_sel", 32'(front_sel), 32'(m_front));
      chk("model swap_done", 32'(swap_done), 32'(m_done));
      chk("model busy", 32'(busy), 32'(m_pending || m_clr_left != 0));
      chk("model write_ready", 32'(write_ready), 32'(!m_pending && m_clr_left == 0));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    write_en = 1'b1; write_addr = AW'(a); write_data = DW'(d);
    tick;
    write_en = 1'b0;
  endtask

  task automatic swap_now;
    swap_req = 1'b1; vsync = 1'b1;
    tick;
    swap_req = 1'b0; vsync = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && busy; i++) tick;
    chk("wait_idle timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " front_sel"}, 32'(front_sel), 32'd0);
    chk({tag, " swap_done"}, 32'(swap_done), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " write_ready"}, 32'(write_ready), 32'd1);
    chk({tag, " read_data"}, 32'(read_data), 32'd0);
  endtask

  int n;

  initial begin
    tick; tick;
    chk_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Write back bank, request swap, take it on vsync
    wr(3, 'hABC);
    swap_req = 1'b1; tick; swap_req = 1'b0;
    chk("pending busy", 32'(busy), 32'd1);
    chk("pending write_ready", 32'(write_ready), 32'd0);
    write_en = 1'b1; write_addr = 3'd5; write_data = 12'h555; swap_req = 1'b1;
    tick;
    write_en = 1'b0; swap_req = 1'b0;
    vsync = 1'b1; read_addr = 3'd3; tick; vsync = 0;
    chk("swap front_sel", 32'(front_sel), 32'd1);
    chk("swap_done pulse", 32'(swap_done), 32'd1);
    chk("read old front", 32'(read_data), 32'd0);
    tick;
    chk("swap_done single", 32'(swap_done), 32'd0);
    chk("read addr3", 32'(read_data), 32'hABC);
    wait_idle;
    vsync = 1'b1; tick; vsync = 1'b0; tick;
    chk("no queued swap", 32'(front_sel), 32'd1);
    read_addr = 3'd5; tick;
    chk("pending write dropped", 32'(read_data), 32'd0);

    // Same-cycle swap_req + vsync from IDLE
    swap_now;
    chk("direct swap front_sel", 32'(front_sel), 32'd0);
    chk("direct swap_done", 32'(swap_done), 32'd1);
    chk("direct swap busy", 32'(busy), 32'(CLR));
    wait_idle;

    // Back bank keeps its data across swaps when no clear runs
    wr(6, 'h3C6);
    swap_req = 1'b1; tick; swap_req = 1'b0;
    vsync = 1'b1; tick; vsync = 1'b0;
    chk("swap3 swap_done", 32'(swap_done), 32'd1);
    chk("busy at swap_done", 32'(busy), 32'(CLR));
    tick;
    chk("busy after swap_done", 32'(busy), 32'(CLR));
    wait_idle;
    read_addr = 3'd3; tick;
    chk("front addr3", 32'(read_data), CLR ? 32'd0 : 32'hABC);
    read_addr = 3'd6; tick;
    chk("front addr6", 32'(read_data), 32'h3C6);

    // Reset wins over same-cycle swap and write
    rst = 1'b1; swap_req = 1'b1; vsync = 1'b1;
    write_en = 1'b1; write_addr = 3'd2; write_data = 12'h777; read_addr = 3'd2;
    tick;
    rst = 1'b0; swap_req = 1'b0; vsync = 1'b0; write_en = 1'b0;
    chk_reset_outputs("rst priority");
    tick;
    chk("rst blocked write", 32'(read_data), 32'd0);

`ifdef FB_CLEAR_EN
    // Clear duration and fill value
    clear_color = 12'h123;
    swap_now;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !write_ready) begin n++; tick; end
      else break;
    end
    chk("clear busy cycles", 32'(n), 32'd8);
    swap_now;
    for (int i = 0; i < N; i++) begin
      read_addr = AW'(i); tick;
      chk("cleared word", 32'(read_data), 32'h123);
    end
    wait_idle;

    // Swap request latched mid-clear; renderer writes ignored while clearing
    clear_color = 12'h321;
    swap_now;
    tick; tick; tick;
    swap_req = 1'b1; write_en = 1'b1; write_addr = 3'd7; write_data = 12'hEEE;
    tick;
    swap_req = 1'b0; write_en = 1'b0;
    tick; tick; tick; tick;
    chk("latched pending busy", 32'(busy), 32'd1);
    chk("latched pending wr_rdy", 32'(write_ready), 32'd0);
    tick; tick;
    chk("latched waits vsync", 32'(front_sel), 32'd1);
    vsync = 1'b1; read_addr = 3'd7; tick; vsync = 1'b0;
    chk("latched swap front", 32'(front_sel), 32'd0);
    chk("latched swap_done", 32'(swap_done), 32'd1);
    tick;
    chk("clear beat write", 32'(read_data), 32'h321);
    wait_idle;

    // Reset during clear leaves the tail of the bank untouched
    swap_now; wait_idle;
    for (int i = 0; i < N; i++) wr(i, 'h200 + i);
    swap_now; wait_idle;
    clear_color = 12'h456;
    swap_now;
    tick; tick; tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk_reset_outputs("clear abort");
    for (int i = 0; i < N; i++) begin
      read_addr = AW'(i); tick;
      chk("partial clear", 32'(read_data), (i < 4) ? 32'h456 : 32'(32'h200 + i));
    end
`endif

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
